rsa_stream_ctrl: RTL and testbench
==================================

// Module: rsa_stream_ctrl
// PURPOSE
// - Streaming front end for the mod_mul exponentiation engine: accepts message words over valid/ready, buffers them,
//   launches one mod_mul operation per word with the programmed exponent/modulus, and returns each result over valid/ready.
// - Sits directly upstream of mod_mul (drives di/exp/n/start, owns its reset) and consumes its done/remainder.
// - Adds range checking, in-order sequence tagging and a completion watchdog.
// PARAMETERS
// - DW          32    data width of message, exponent, modulus (matches mod_mul)
// - FIFO_DEPTH  4     input buffer entries (power of 2, >=2)
// - TAG_W       8     width of per-message sequence tag
// - TIMEOUT     4096  max cycles in WAIT before abort
// PORTS
// - clk            in   1       clock, rising edge
// - reset          in   1       synchronous, active-low reset
// - cfg_we         in   1       load cfg_exp/cfg_n; honoured only when busy=0
// - cfg_exp        in   DW      exponent
// - cfg_n          in   DW      modulus
// - in_valid       in   1       message word valid
// - in_ready       out  1       = !fifo_full
// - in_data        in   DW      message word m
// - out_valid      out  1       result valid; held until out_ready
// - out_ready      in   1       downstream accept
// - out_data       out  DW      m^e mod n from engine (0 when out_err)
// - out_tag        out  TAG_W   sequence number of this message
// - out_err        out  1       range error or watchdog abort
// - busy           out  1       FSM not IDLE or FIFO non-empty
// - mm_clr         out  1       active-high sync reset to mod_mul (OR with ~reset at instance)
// - mm_start       out  1       one-cycle start pulse
// - mm_di/mm_exp/mm_n out DW    operands; stable from LAUNCH until leaving WAIT
// - mm_done        in   1       engine done (sticky until mm_clr)
// - mm_remainder   in   DW      engine result
// BEHAVIOUR
// - Reset (reset=0 at edge): FSM=IDLE, FIFO empty, tag=0, exp/n regs=0, all outputs 0 except in_ready=1.
// - FIFO: push when in_valid&in_ready; pop only in IDLE->CHECK. Push+pop same cycle when full: push blocked (in_ready=0).
// - FSM: IDLE -> CHECK when FIFO non-empty and !out_valid; pops head into m_reg.
//   CHECK: if n_reg<2 or m_reg>=n_reg -> OUT with out_err=1, out_data=0 (no engine launch); else -> CLEAR.
//   CLEAR: mm_clr=1 one cycle (clears mod_mul's sticky done) -> LAUNCH.
//   LAUNCH: mm_start=1 one cycle, watchdog cnt=0 -> WAIT.
//   WAIT: mm_done=1 -> capture mm_remainder, out_err=0 -> OUT; cnt==TIMEOUT-1 -> out_err=1, out_data=0, mm_clr=1 -> OUT.
//   OUT: out_valid=1 with out_tag=tag; on out_ready: out_valid=0, tag<=tag+1 (wraps mod 2^TAG_W), -> IDLE.
// - Min latency pop->out_valid: 4 cycles + engine latency. One message in flight; results strictly in order.
// - mm_done ignored outside WAIT. Tag advances on errored messages too.
// - cfg_we while busy=1 ignored (no partial update); cfg_we with in_valid same cycle in idle: cfg loads, message uses new cfg.
// - Reset mid-operation: FSM aborts immediately, mm_clr is don't-care because instance reset covers mod_mul; buffered words dropped.
// STRUCTURE
// - rsa_pkg: DW, state enum {IDLE,CHECK,CLEAR,LAUNCH,WAIT,OUT} (logic [2:0]).
// - Sub-module rsa_in_fifo (sync FIFO, DEPTH/DW params, full/empty, same active-low reset).
// - Watchdog counter width $clog2(TIMEOUT); tag counter TAG_W.
// TESTING (bench uses behavioural mod_mul stub: sticky done, result m^e mod n after programmable latency)
// - cfg exp=3,n=33; send m=5 -> out_data=26, out_tag=0, out_err=0; mm_clr precedes mm_start by 1 cycle.
// - Send m=40 with n=33 -> out_err=1, out_data=0, mm_start never pulses; next m=2 -> out_data=8, tag=1.
// - Burst 6 words, out_ready=0 -> in_ready drops after FIFO fills; release -> 6 results in order, tags 0..5.
// - Stub latency > TIMEOUT -> out_err=1 at exactly TIMEOUT cycles after mm_start; next message completes normally.
// - cfg_we with exp=7 during WAIT -> ignored, result uses exp=3; cfg_n=1 then m=0 -> out_err=1.
// - Assert reset=0 during WAIT with 2 words queued -> all outputs at reset values next cycle, in_ready=1, tag=0.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA streaming front end.
package rsa_pkg;

    // Default data width of message, exponent and modulus (matches mod_mul).
    localparam int RSA_DW = 32;

    // Controller states; one message is in flight at a time.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_WAIT   = 3'd4,
        ST_OUT    = 3'd5
    } state_t;

endpackage

// File: rtl/rsa_stream_ctrl_if.sv
// Message-in / result-out stream bundle of the RSA streaming front end.
//
// Handshake: a word moves on a rising clock edge exactly when valid and ready
// are both 1 at that edge. A producer holds valid and its payload stable until
// the transfer happens; ready may change freely and never depends on valid
// being deasserted first.
interface rsa_stream_ctrl_if #(
    parameter int DW    = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    // Environment side: supplies messages, consumes results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/rsa_in_fifo.sv
// Small synchronous FIFO buffering incoming message words.
// Push is ignored when full, pop is ignored when empty.
module rsa_in_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/rsa_stream_ctrl.sv
// Streaming front end for the mod_mul exponentiation engine: buffers message
// words, range-checks each one, runs one engine operation per word and returns
// tagged results strictly in order, aborting stuck operations with a watchdog.
module rsa_stream_ctrl
    import rsa_pkg::*;
#(
    parameter int DW         = RSA_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [DW-1:0] cfg_exp,
    input  logic [DW-1:0] cfg_n,
    rsa_stream_ctrl_if.slave s,
    output logic          busy,
    output logic          mm_clr,
    output logic          mm_start,
    output logic [DW-1:0] mm_di,
    output logic [DW-1:0] mm_exp,
    output logic [DW-1:0] mm_n,
    input  logic          mm_done,
    input  logic [DW-1:0] mm_remainder,
    output state_t        o_dbg_state
);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t           r_state;
    logic [DW-1:0]    r_m;
    logic [DW-1:0]    r_exp;
    logic [DW-1:0]    r_n;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic             r_out_err;
    logic [DW-1:0]    r_out_data;
    logic             r_mm_clr;
    logic             r_mm_start;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [DW-1:0]    w_fifo_rdata;
    logic             w_push;
    logic             w_pop;
    logic             w_busy;
    logic             w_cfg_load;

    // A word leaves the buffer only when the controller is idle with no result pending.
    assign w_push     = s.in_valid & ~w_fifo_full;
    assign w_pop      = (r_state == ST_IDLE) & ~w_fifo_empty & ~r_out_valid;
    assign w_busy     = (r_state != ST_IDLE) | ~w_fifo_empty;
    // Configuration is only taken while nothing is queued or in flight.
    assign w_cfg_load = cfg_we & ~w_busy;

    rsa_in_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (s.in_data),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Controller FSM with registered engine controls, result and configuration.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_m         <= '0;
            r_exp       <= '0;
            r_n         <= '0;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= '0;
            r_mm_clr    <= 1'b0;
            r_mm_start  <= 1'b0;
        end else begin
            if (w_cfg_load) begin
                r_exp <= cfg_exp;
                r_n   <= cfg_n;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_m     <= w_fifo_rdata;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Out-of-range operands never reach the engine.
                    if ((r_n < DW'(2)) || (r_m >= r_n)) begin
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b1;
                        r_out_data  <= '0;
                        r_state     <= ST_OUT;
                    end else begin
                        r_mm_clr <= 1'b1;
                        r_state  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // Engine's sticky done from the previous word is now cleared.
                    r_mm_clr   <= 1'b0;
                    r_mm_start <= 1'b1;
                    r_state    <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    r_mm_start <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mm_done) begin
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b0;
                        r_out_data  <= mm_remainder;
                        r_state     <= ST_OUT;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Watchdog abort: also reset the engine so it stops working.
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b1;
                        r_out_data  <= '0;
                        r_mm_clr    <= 1'b1;
                        r_state     <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    r_mm_clr <= 1'b0;
                    if (s.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_err   <= 1'b0;
                        r_tag       <= r_tag + 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s.in_ready   = ~w_fifo_full;
    assign s.out_valid  = r_out_valid;
    assign s.out_err    = r_out_err;
    assign s.out_data   = r_out_data;
    assign s.out_tag    = r_tag;
    assign busy         = w_busy;
    assign mm_clr       = r_mm_clr;
    assign mm_start     = r_mm_start;
    assign mm_di        = r_m;
    assign mm_exp       = r_exp;
    assign mm_n         = r_n;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Self-checking bench for rsa_stream_ctrl with a behavioural mod_mul stub.
module tb_rsa_stream_ctrl;
    import rsa_pkg::*;

    localparam int DW         = 32;
    localparam int TAG_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 64;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          cfg_we  = 1'b0;
    logic [DW-1:0] cfg_exp = '0;
    logic [DW-1:0] cfg_n   = '0;
    logic          busy;
    logic          mm_clr;
    logic          mm_start;
    logic [DW-1:0] mm_di;
    logic [DW-1:0] mm_exp;
    logic [DW-1:0] mm_n;
    logic          mm_done      = 1'b0;
    logic [DW-1:0] mm_remainder = '0;
    state_t        dbg_state;

    rsa_stream_ctrl_if #(.DW(DW), .TAG_W(TAG_W)) sif ();

    rsa_stream_ctrl #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_exp      (cfg_exp),
        .cfg_n        (cfg_n),
        .s            (sif),
        .busy         (busy),
        .mm_clr       (mm_clr),
        .mm_start     (mm_start),
        .mm_di        (mm_di),
        .mm_exp       (mm_exp),
        .mm_n         (mm_n),
        .mm_done      (mm_done),
        .mm_remainder (mm_remainder),
        .o_dbg_state  (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Plain square-and-multiply reference for m^e mod n.
    function automatic logic [DW-1:0] modexp(input logic [DW-1:0] m, input logic [DW-1:0] e,
                                             input logic [DW-1:0] n);
        longint unsigned r, b, nn;
        if (n == 0) return '0;
        nn = 64'(n);
        r  = 1 % nn;
        b  = 64'(m) % nn;
        for (int i = 0; i < DW; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return DW'(r);
    endfunction

    // ---------------- mod_mul stub: sticky done after stub_lat cycles ----------------
    int stub_lat = 3;
    logic stub_run = 1'b0;
    int stub_cnt = 0;
    always @(posedge clk) begin
        if (!reset || mm_clr) begin
            mm_done  <= 1'b0;
            stub_run <= 1'b0;
            stub_cnt <= 0;
        end else if (mm_start) begin
            stub_run     <= 1'b1;
            stub_cnt     <= stub_lat;
            mm_remainder <= modexp(mm_di, mm_exp, mm_n);
        end else if (stub_run) begin
            if (stub_cnt <= 1) begin
                mm_done  <= 1'b1;
                stub_run <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // ---------------- behavioural model + scoreboard ----------------
    logic [DW-1:0]    exp_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    logic [0:0]       exp_err_q[$];
    logic [DW-1:0]    got_q[$];
    logic [TAG_W-1:0] got_tag_q[$];
    logic [0:0]       got_err_q[$];
    logic [DW-1:0]    m_exp = '0;
    logic [DW-1:0]    m_n   = '0;
    logic [TAG_W-1:0] m_tag = '0;
    int               outstanding = 0;
    int               cyc = 0;
    int               starts = 0;
    int               last_start_cyc = 0;
    int               last_rise_cyc = 0;
    logic             prev_clr = 1'b0;
    logic             prev_ov  = 1'b0;

    // One compare process: checks the outputs present this cycle, then
    // advances the model for whatever the coming edge will do.
    always @(negedge clk) begin
        logic [DW-1:0] d;
        logic          e;
        cyc++;
        if (mm_start) begin
            starts++;
            last_start_cyc = cyc;
            check("clr_before_start", prev_clr, 1);
        end
        if (sif.out_valid && !prev_ov) last_rise_cyc = cyc;
        check("busy", busy, outstanding != 0);
        if (sif.out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", sif.out_valid, 0);
            end else begin
                check("out_data", sif.out_data, exp_q[0]);
                check("out_tag", sif.out_tag, exp_tag_q[0]);
                check("out_err", sif.out_err, exp_err_q[0]);
            end
        end
        prev_clr = mm_clr;
        prev_ov  = sif.out_valid;

        if (!reset) begin
            exp_q.delete();
            exp_tag_q.delete();
            exp_err_q.delete();
            outstanding = 0;
            m_tag = '0;
            m_exp = '0;
            m_n   = '0;
        end else begin
            if (cfg_we && outstanding == 0) begin
                m_exp = cfg_exp;
                m_n   = cfg_n;
            end
            if (sif.out_valid && sif.out_ready && exp_q.size() > 0) begin
                got_q.push_back(sif.out_data);
                got_tag_q.push_back(sif.out_tag);
                got_err_q.push_back(sif.out_err);
                void'(exp_q.pop_front());
                void'(exp_tag_q.pop_front());
                void'(exp_err_q.pop_front());
                outstanding--;
            end
            if (sif.in_valid && sif.in_ready) begin
                if (m_n < 2 || sif.in_data >= m_n) begin
                    d = '0; e = 1'b1;
                end else if (stub_lat >= TIMEOUT) begin
                    d = '0; e = 1'b1;
                end else begin
                    d = modexp(sif.in_data, m_exp, m_n); e = 1'b0;
                end
                exp_q.push_back(d);
                exp_tag_q.push_back(m_tag);
                exp_err_q.push_back(e);
                m_tag = m_tag + 1'b1;
                outstanding++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data = '0;
        sif.out_ready = 1'b1;
        cfg_we = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        got_q.delete();
        got_tag_q.delete();
        got_err_q.delete();
    endtask

    task automatic set_cfg(input logic [DW-1:0] e, input logic [DW-1:0] n);
        cfg_we = 1'b1;
        cfg_exp = e;
        cfg_n = n;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] m);
        int k;
        k = 0;
        sif.in_valid = 1'b1;
        sif.in_data = m;
        @(negedge clk);
        while (!sif.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!sif.in_ready) check("send_accept", sif.in_ready, 1);
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 2000) begin
            tick(1);
            k++;
        end
        check("result_count", got_q.size(), n);
    endtask

    task automatic check_got(input string name, input int idx, input logic [DW-1:0] d,
                             input logic [TAG_W-1:0] t, input logic e);
        if (got_q.size() > idx) begin
            check({name, "_data"}, got_q[idx], d);
            check({name, "_tag"}, got_tag_q[idx], t);
            check({name, "_err"}, got_err_q[idx], e);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, sif.in_ready, 1);
        check({name, "_out_valid"}, sif.out_valid, 0);
        check({name, "_out_err"}, sif.out_err, 0);
        check({name, "_out_data"}, sif.out_data, 0);
        check({name, "_out_tag"}, sif.out_tag, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_mm_clr"}, mm_clr, 0);
        check({name, "_mm_start"}, mm_start, 0);
        check({name, "_mm_di"}, mm_di, 0);
        check({name, "_mm_exp"}, mm_exp, 0);
        check({name, "_mm_n"}, mm_n, 0);
        check({name, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- directed scenarios ----------------
    int starts0;
    int burst_acc;
    logic [DW-1:0] burst_res [6];

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data = '0;
        sif.out_ready = 1'b1;

        // Reset values, then 5^3 mod 33 = 26.
        do_reset();
        check_reset_outputs("reset");
        set_cfg(3, 33);
        starts0 = starts;
        send_word(5);
        wait_results(1);
        check_got("m5", 0, 26, 0, 0);
        check("m5_starts", starts - starts0, 1);

        // Range error (40 >= 33) skips the engine; next word gets tag 1.
        do_reset();
        set_cfg(3, 33);
        starts0 = starts;
        send_word(40);
        wait_results(1);
        check_got("m40", 0, 0, 0, 1);
        check("m40_starts", starts - starts0, 0);
        send_word(2);
        wait_results(2);
        check_got("m2", 1, 8, 1, 0);
        check("m2_starts", starts - starts0, 1);

        // Burst of 6 with output stalled: one in flight plus 4 buffered.
        do_reset();
        set_cfg(3, 33);
        sif.out_ready = 1'b0;
        burst_acc = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    send_word(DW'(i));
                    burst_acc++;
                end
            end
        join_none
        tick(40);
        check("burst_in_ready", sif.in_ready, 0);
        check("burst_accepted", burst_acc, 5);
        sif.out_ready = 1'b1;
        wait_results(6);
        burst_res = '{1, 8, 27, 31, 26, 18};
        for (int i = 0; i < 6; i++) check_got("burst", i, burst_res[i], TAG_W'(i), 0);

        // Watchdog: engine sees start one edge after the pulse, abort TIMEOUT edges later.
        do_reset();
        set_cfg(3, 33);
        stub_lat = 200;
        send_word(5);
        wait_results(1);
        check_got("wdog", 0, 0, 0, 1);
        check("wdog_latency", last_rise_cyc - last_start_cyc, TIMEOUT + 1);
        stub_lat = 3;
        send_word(2);
        wait_results(2);
        check_got("after_wdog", 1, 8, 1, 0);

        // cfg write while busy is ignored: 4^3 mod 33 = 31 (not 4^7 mod 33 = 16).
        do_reset();
        set_cfg(3, 33);
        stub_lat = 20;
        send_word(4);
        tick(8);
        check("cfg_busy_state", dbg_state, ST_WAIT);
        set_cfg(7, 33);
        wait_results(1);
        check_got("cfg_ignored", 0, 31, 0, 0);
        stub_lat = 3;
        set_cfg(3, 1);
        send_word(0);
        wait_results(2);
        check_got("n_is_1", 1, 0, 1, 1);

        // Reset during WAIT with two words buffered.
        do_reset();
        set_cfg(3, 33);
        stub_lat = 50;
        send_word(3);
        send_word(6);
        send_word(7);
        tick(6);
        check("mid_state", dbg_state, ST_WAIT);
        check("mid_busy", busy, 1);
        reset = 1'b0;
        tick(1);
        check_reset_outputs("mid_reset");
        reset = 1'b1;
        tick(2);
        check("post_reset_busy", busy, 0);
        got_q.delete();
        got_tag_q.delete();
        got_err_q.delete();
        stub_lat = 3;
        set_cfg(3, 33);
        send_word(2);
        wait_results(1);
        check_got("post_reset", 0, 8, 0, 0);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, cycles=%0d", cyc);
        $fatal(1, "time limit");
    end
endmodule
